regfile_wb: RTL

Architectural register file and writeback sink for the RV32I core. It takes the selected writeback value (ALU result, PC+4, load data, immediate) over a valid/ready handshake. Each value is staged in a one-entry writeback holding register and committed to a 32 x 32 register array. A per-register pending-write scoreboard and a bypass path give the decode stage correct operands and hazard flags.

---
 rtl/regfile_wb.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// RV32I architectural register file with a one-entry writeback holding register,
// a pending-write scoreboard and a bypass from the holding register to both read ports.
module regfile_wb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_stall,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_sb;
    logic            r_hold_valid;
    logic [AW-1:0]   r_hold_rd;
    logic [XLEN-1:0] r_hold_data;

    logic            w_xfer;
    logic            w_commit;
    logic [NREG-1:0] w_sb_next;

    assign wb_ready = !r_hold_valid || !wb_stall;
    assign w_xfer   = wb_valid && wb_ready;
    assign w_commit = r_hold_valid && !wb_stall;

    // Commit clears before issue sets, so a same-edge issue of the committing rd stays pending.
    always_comb begin
        w_sb_next = r_sb;
        if (w_commit) begin
            w_sb_next[r_hold_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_sb_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because software may read any register
            // before writing it; this forces flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_sb         <= '0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
        end else begin
            if (w_commit && (r_hold_rd != '0)) begin
                r_regs[r_hold_rd] <= r_hold_data;
            end
            if (w_xfer) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= wb_rd;
                r_hold_data  <= wb_data;
            end else if (w_commit) begin
                r_hold_valid <= 1'b0;
            end
            r_sb <= w_sb_next;
        end
    end

    // Read priority: x0, then the holding register bypass, then the array.
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs1_busy = r_sb[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end else if (r_hold_valid && (r_hold_rd == rs1_addr)) begin
            rs1_data = r_hold_data;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = r_regs[rs2_addr];
        rs2_busy = r_sb[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end else if (r_hold_valid && (r_hold_rd == rs2_addr)) begin
            rs2_data = r_hold_data;
            rs2_busy = 1'b0;
        end
    end

endmodule
